i2c_master_sequencer: RTL and testbench

I2C_MASTER_SEQUENCER -- requirements
Module: i2c_master_sequencer

---
 rtl/i2c_master_sequencer_if.sv | 47 ++++
 rtl/i2c_master_sequencer.sv | 137 +++++++++++++
 tb/tb_i2c_master_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_sequencer_if.sv
// Host, bit-timer and bus-level signals of the I2C master sequencer.
// master: the side that drives requests and timer/bus status (host + bit timer).
// slave:  the sequencer itself.
interface i2c_master_sequencer_if;
    logic [31:0] clock_div;
    logic        go;
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  byte_count;
    logic        tx_valid;
    logic        tx_ready;
    logic        shift_load;
    logic        shift_sel;
    logic        rx_push;
    logic        timer_active;
    logic        direction;
    logic        should_nack;
    logic        byte_complete;
    logic        ack;
    logic        abort;
    logic        SDA_sync;
    logic        SCL_sync;
    logic        seq_SDA_out;
    logic        seq_SCL_out;
    logic        timer_owns_bus;
    logic        busy;
    logic        done;
    logic        err_nack;
    logic        err_arb;
    logic        err_busy;

    modport master (
        output clock_div, go, addr, rw, byte_count, tx_valid,
               byte_complete, ack, abort, SDA_sync, SCL_sync,
        input  tx_ready, shift_load, shift_sel, rx_push, timer_active,
               direction, should_nack, seq_SDA_out, seq_SCL_out,
               timer_owns_bus, busy, done, err_nack, err_arb, err_busy
    );

    modport slave (
        input  clock_div, go, addr, rw, byte_count, tx_valid,
               byte_complete, ack, abort, SDA_sync, SCL_sync,
        output tx_ready, shift_load, shift_sel, rx_push, timer_active,
               direction, should_nack, seq_SDA_out, seq_SCL_out,
               timer_owns_bus, busy, done, err_nack, err_arb, err_busy
    );
endinterface

// File: rtl/i2c_master_sequencer.sv
// I2C master transaction sequencer: START, address byte, data bytes via an
// external bit timer, STOP, with sticky NACK / arbitration / busy-bus status.
module i2c_master_sequencer #(
    parameter int unsigned MAX_BYTES = 255
) (
    input  logic                      clk,
    input  logic                      n_rst,
    i2c_master_sequencer_if.slave     bus
);

    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] START_SETUP = 4'd1;
    localparam logic [3:0] START_HOLD  = 4'd2;
    localparam logic [3:0] LOAD        = 4'd3;
    localparam logic [3:0] BYTE        = 4'd4;
    localparam logic [3:0] CHECK       = 4'd5;
    localparam logic [3:0] STOP_LOW    = 4'd6;
    localparam logic [3:0] STOP_SCL    = 4'd7;
    localparam logic [3:0] STOP_SDA    = 4'd8;
    localparam logic [3:0] FINISH      = 4'd9;

    localparam logic [7:0] MAX_B = MAX_BYTES[7:0];

    logic [3:0]  state, next_state;
    logic [31:0] phase_cnt, div_q;
    logic        rw_q, first_q;
    logic [7:0]  remaining, rem_after;
    logic        done_q, err_nack_q, err_arb_q, err_busy_q;
    logic        phase_done, bus_free, go_ok, tx_nack;

    assign phase_done = (phase_cnt == div_q);
    assign bus_free   = bus.SDA_sync & bus.SCL_sync;
    assign go_ok      = (state == IDLE) & bus.go;
    // The address byte's NACK and a write byte's NACK both end the transfer;
    // on read bytes ack is our own ACK/NACK, not a status.
    assign tx_nack    = (first_q | ~rw_q) & bus.ack;
    // The address byte does not consume a data byte; no wrap below zero.
    assign rem_after  = first_q ? remaining :
                        (remaining == 8'd0) ? 8'd0 : remaining - 8'd1;

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (bus.go && bus_free) next_state = START_SETUP;
            START_SETUP: if (phase_done) next_state = START_HOLD;
            START_HOLD:  if (phase_done) next_state = LOAD;
            LOAD:        if (first_q || rw_q || bus.tx_valid) next_state = BYTE;
            BYTE: begin
                if (bus.abort)              next_state = IDLE;
                else if (bus.byte_complete) next_state = CHECK;
            end
            CHECK: begin
                if (tx_nack || rem_after == 8'd0) next_state = STOP_LOW;
                else                              next_state = LOAD;
            end
            STOP_LOW:    if (phase_done) next_state = STOP_SCL;
            STOP_SCL:    if (phase_done && bus.SCL_sync) next_state = STOP_SDA;
            STOP_SDA:    if (phase_done) next_state = FINISH;
            FINISH:      next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // State, phase counter, captured request and sticky status
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            phase_cnt  <= 32'd0;
            div_q      <= 32'd0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            remaining  <= 8'd0;
            done_q     <= 1'b0;
            err_nack_q <= 1'b0;
            err_arb_q  <= 1'b0;
            err_busy_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= 1'b0;
            if (next_state != state)  phase_cnt <= 32'd0;
            else if (!phase_done)     phase_cnt <= phase_cnt + 32'd1;

            if (go_ok) begin
                div_q      <= bus.clock_div;
                rw_q       <= bus.rw;
                first_q    <= 1'b1;
                remaining  <= (bus.byte_count > MAX_B) ? MAX_B : bus.byte_count;
                err_nack_q <= 1'b0;
                err_arb_q  <= 1'b0;
                err_busy_q <= ~bus_free;
                done_q     <= ~bus_free;
            end

            if (state == BYTE && bus.abort) begin
                err_arb_q <= 1'b1;
                done_q    <= 1'b1;
            end

            if (state == CHECK) begin
                remaining <= rem_after;
                first_q   <= 1'b0;
                if (tx_nack) err_nack_q <= 1'b1;
            end
        end
    end

    // START/STOP bus levels; released (high) outside those phases
    always_comb begin
        bus.seq_SDA_out = 1'b1;
        bus.seq_SCL_out = 1'b1;
        case (state)
            START_HOLD: bus.seq_SDA_out = 1'b0;
            LOAD, BYTE, CHECK, STOP_LOW: begin
                bus.seq_SDA_out = 1'b0;
                bus.seq_SCL_out = 1'b0;
            end
            STOP_SCL:   bus.seq_SDA_out = 1'b0;
            default: ;
        endcase
    end

    assign bus.busy           = (state != IDLE);
    assign bus.timer_active   = (state == BYTE);
    assign bus.timer_owns_bus = (state == BYTE);
    assign bus.direction      = first_q | ~rw_q;
    assign bus.should_nack    = (state == BYTE) & ~first_q & rw_q & (remaining == 8'd1);
    assign bus.shift_load     = (state == LOAD) & (first_q | (~rw_q & bus.tx_valid));
    assign bus.shift_sel      = ~first_q;
    assign bus.tx_ready       = (state == LOAD) & ~first_q & ~rw_q & bus.tx_valid;
    assign bus.rx_push        = (state == CHECK) & ~first_q & rw_q;
    assign bus.done           = done_q | (state == FINISH);
    assign bus.err_nack       = err_nack_q;
    assign bus.err_arb        = err_arb_q;
    assign bus.err_busy       = err_busy_q;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed bench for i2c_master_sequencer with a small bit-timer/bus model.
module tb_i2c_master_sequencer;

    logic clk;
    logic n_rst;
    i2c_master_sequencer_if bus ();

    i2c_master_sequencer #(.MAX_BYTES(255)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus controls for the bit-timer / bus model
    int   nack_win   = -1;
    int   abort_win  = -1;
    logic stretch_en = 1'b0;
    logic scl_low    = 1'b0;

    // Bit-timer and bus model: completes each byte window after 3 cycles,
    // optionally NACKs/aborts a chosen window and stretches SCL during STOP.
    initial begin
        int   wc, win, sc;
        logic stretching;
        wc = 0; win = 0; sc = 0; stretching = 1'b0;
        bus.byte_complete = 1'b0;
        bus.abort         = 1'b0;
        bus.ack           = 1'b0;
        bus.SDA_sync      = 1'b1;
        bus.SCL_sync      = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!n_rst || !bus.busy) begin
                wc = 0; win = 0; sc = 0; stretching = 1'b0;
                bus.byte_complete = 1'b0;
                bus.abort         = 1'b0;
            end else begin
                if (bus.timer_active) begin
                    wc++;
                    if (wc == 3) begin
                        if (win == abort_win) bus.abort = 1'b1;
                        else begin
                            bus.byte_complete = 1'b1;
                            bus.ack = (win == nack_win);
                        end
                        win++;
                    end
                end else begin
                    wc = 0;
                    bus.byte_complete = 1'b0;
                    bus.abort = 1'b0;
                end
                if (stretch_en && win > 0 && !bus.timer_owns_bus &&
                    bus.seq_SCL_out && !bus.seq_SDA_out) begin
                    sc++;
                    stretching = (sc < 9);
                end else stretching = 1'b0;
            end
            bus.SCL_sync = ~(scl_low | stretching);
        end
    end

    // Monitor: per-transaction event counters, sampled on the falling edge
    int   clr_id = 0, seen_clr = 0;
    int   wins, txr, rxp, sld, dones, setup_c, hold_c, stopscl_c, ta_late;
    logic [7:0] snack;
    logic prev_ta, prev_bc;
    initial begin
        wins = 0; txr = 0; rxp = 0; sld = 0; dones = 0;
        setup_c = 0; hold_c = 0; stopscl_c = 0; ta_late = 0; snack = '0;
        prev_ta = 1'b0; prev_bc = 1'b0;
    end
    always @(negedge clk) begin
        if (clr_id != seen_clr) begin
            wins = 0; txr = 0; rxp = 0; sld = 0; dones = 0;
            setup_c = 0; hold_c = 0; stopscl_c = 0; ta_late = 0; snack = '0;
            seen_clr = clr_id;
        end else begin
            if (bus.timer_active && !prev_ta) wins++;
            if (bus.timer_active && prev_bc) ta_late++;
            if (bus.timer_active && bus.should_nack && wins > 0 && wins <= 8) snack[wins-1] = 1'b1;
            if (bus.tx_ready)   txr++;
            if (bus.rx_push)    rxp++;
            if (bus.shift_load) sld++;
            if (bus.done)       dones++;
            if (bus.busy && !bus.timer_owns_bus) begin
                if (wins == 0 && bus.seq_SDA_out && bus.seq_SCL_out)  setup_c++;
                if (wins == 0 && !bus.seq_SDA_out && bus.seq_SCL_out) hold_c++;
                if (wins > 0 && !bus.seq_SDA_out && bus.seq_SCL_out)  stopscl_c++;
            end
        end
        prev_ta = bus.timer_active;
        prev_bc = bus.timer_active && (bus.byte_complete || bus.abort);
    end

    // Issue one transaction and wait (bounded) for its done pulse
    task automatic run(input logic r, input logic [7:0] n, input logic dbl_go);
        int i;
        clr_id++;
        @(negedge clk);
        bus.addr = 7'h50; bus.rw = r; bus.byte_count = n; bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        if (dbl_go) begin
            repeat (20) @(negedge clk);
            bus.go = 1'b1;
            @(negedge clk);
            bus.go = 1'b0;
        end
        i = 0;
        while (dones == 0 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("done_timeout", (dones != 0), 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int i;
        n_rst = 1'b0;
        bus.clock_div = 32'd4; bus.go = 1'b0; bus.addr = 7'h50; bus.rw = 1'b0;
        bus.byte_count = 8'd0; bus.tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_sda", bus.seq_SDA_out, 1);
        check("rst_scl", bus.seq_SCL_out, 1);
        check("rst_ta", bus.timer_active, 0);
        check("rst_owns", bus.timer_owns_bus, 0);
        check("rst_done", bus.done, 0);
        check("rst_errs", {bus.err_nack, bus.err_arb, bus.err_busy}, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write 2 bytes, with a second go while busy that must be ignored
        run(1'b0, 8'd2, 1'b1);
        check("wr_wins", wins, 3);
        check("wr_txready", txr, 2);
        check("wr_load", sld, 3);
        check("wr_rxpush", rxp, 0);
        check("wr_done", dones, 1);
        check("wr_setup", setup_c, 5);
        check("wr_hold", hold_c, 5);
        check("wr_stopscl", stopscl_c, 5);
        check("wr_errs", {bus.err_nack, bus.err_arb, bus.err_busy}, 0);
        check("wr_talate", ta_late, 0);
        check("wr_snack", snack, 0);

        // Read 3 bytes, SCL stretched in STOP
        stretch_en = 1'b1;
        run(1'b1, 8'd3, 1'b0);
        stretch_en = 1'b0;
        check("rd_wins", wins, 4);
        check("rd_rxpush", rxp, 3);
        check("rd_load", sld, 1);
        check("rd_txready", txr, 0);
        check("rd_snack", snack, 8'b0000_1000);
        check("rd_stopscl", stopscl_c, 9);
        check("rd_done", dones, 1);
        check("rd_errs", {bus.err_nack, bus.err_arb, bus.err_busy}, 0);

        // Address NACK
        nack_win = 0;
        run(1'b0, 8'd2, 1'b0);
        nack_win = -1;
        check("nk_wins", wins, 1);
        check("nk_err", bus.err_nack, 1);
        check("nk_stopscl", stopscl_c, 5);
        check("nk_txready", txr, 0);
        check("nk_done", dones, 1);

        // Abort in the second window
        abort_win = 1;
        run(1'b0, 8'd2, 1'b0);
        abort_win = -1;
        check("ab_wins", wins, 2);
        check("ab_errarb", bus.err_arb, 1);
        check("ab_errnack", bus.err_nack, 0);
        check("ab_stopscl", stopscl_c, 0);
        check("ab_done", dones, 1);
        check("ab_bus", {bus.seq_SDA_out, bus.seq_SCL_out}, 2'b11);
        check("ab_busy", bus.busy, 0);

        // Address-only probe; also clears the sticky err_arb
        run(1'b0, 8'd0, 1'b0);
        check("pr_wins", wins, 1);
        check("pr_stopscl", stopscl_c, 5);
        check("pr_done", dones, 1);
        check("pr_errs", {bus.err_nack, bus.err_arb, bus.err_busy}, 0);

        // Busy bus: SCL low at go
        scl_low = 1'b1;
        repeat (2) @(negedge clk);
        clr_id++;
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        check("bb_done", bus.done, 1);
        check("bb_errbusy", bus.err_busy, 1);
        check("bb_bus", {bus.seq_SDA_out, bus.seq_SCL_out}, 2'b11);
        @(negedge clk);
        check("bb_done_once", bus.done, 0);
        check("bb_busy", bus.busy, 0);
        scl_low = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during START_HOLD, then a clean transaction
        clr_id++;
        @(negedge clk);
        bus.rw = 1'b0; bus.byte_count = 8'd2; bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        i = 0;
        while (hold_c == 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("mr_reach_hold", (hold_c != 0), 1);
        #2 n_rst = 1'b0;
        #1;
        check("mr_busy", bus.busy, 0);
        check("mr_bus", {bus.seq_SDA_out, bus.seq_SCL_out}, 2'b11);
        check("mr_ta", {bus.timer_active, bus.timer_owns_bus}, 0);
        check("mr_pulses", {bus.done, bus.tx_ready, bus.shift_load, bus.rx_push}, 0);
        check("mr_errs", {bus.err_nack, bus.err_arb, bus.err_busy}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        run(1'b0, 8'd2, 1'b0);
        check("mr_wins", wins, 3);
        check("mr_txready", txr, 2);
        check("mr_done", dones, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
